sad_ctrl: RTL and testbench

- Control FSM for the 256-element sum-of-absolute-differences datapath.
- Drives the datapath's clear, load and increment strobes, and reads back its loop-status flag (i_lt_256).
- Sequences one SAD computation per go request, then signals completion to the host (CPU/MIPS glue).
- Supports a configurable memory read latency, abort, a host-requested result clear, and a length-mismatch error flag.

---
 rtl/sad_ctrl.sv | 93 +++++++++
 tb/tb_sad_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sad_ctrl.sv
// sad_ctrl: control FSM sequencing one 256-element SAD computation per go request.
module sad_ctrl #(
    parameter int RD_LAT = 0,
    parameter int N_ELEM = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic abort,
    input  logic clr_sad,
    input  logic i_lt_256,
    output logic i_inc,
    output logic i_clr,
    output logic sum_ld,
    output logic sum_clr,
    output logic sadreg_ld,
    output logic sadreg_clr,
    output logic busy,
    output logic done,
    output logic err
);
    localparam int WW = $clog2(RD_LAT + 2);
    typedef enum logic [2:0] {S_IDLE, S_INIT, S_WAIT, S_ACC, S_STORE, S_DONE} state_t;
    localparam state_t S_LOOP = (RD_LAT > 0) ? S_WAIT : S_ACC;
    state_t r_state, w_next;
    logic [8:0] r_cnt;
    logic [WW-1:0] r_wcnt;
    logic r_err;
    logic w_last, w_abort, w_start;
    assign w_last  = (r_cnt == 9'(N_ELEM - 1));
    assign w_abort = abort && (r_state == S_INIT || r_state == S_WAIT || r_state == S_ACC);
    assign w_start = (r_state == S_IDLE) && go && !abort;
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign err     = r_err;
    always_comb begin
        w_next     = r_state;
        i_inc      = 1'b0;
        i_clr      = 1'b0;
        sum_ld     = 1'b0;
        sum_clr    = 1'b0;
        sadreg_ld  = 1'b0;
        sadreg_clr = 1'b0;
        if (w_abort) begin
            i_clr   = 1'b1;
            sum_clr = 1'b1;
            w_next  = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    sadreg_clr = clr_sad;
                    w_next     = w_start ? S_INIT : S_IDLE;
                end
                S_INIT: begin
                    i_clr   = 1'b1;
                    sum_clr = 1'b1;
                    w_next  = S_LOOP;
                end
                S_WAIT: w_next = (r_wcnt == '0) ? S_ACC : S_WAIT;
                S_ACC: begin
                    sum_ld = 1'b1;
                    i_inc  = i_lt_256 && !w_last;
                    w_next = i_inc ? S_LOOP : S_STORE;
                end
                S_STORE: begin
                    sadreg_ld = 1'b1;
                    w_next    = S_DONE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end
    // A load that leaves the loop early, or one that would run past N_ELEM, flags a length mismatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_wcnt  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wcnt  <= (r_state == S_WAIT) ? r_wcnt - 1'b1 : WW'(RD_LAT > 0 ? RD_LAT - 1 : 0);
            if (r_state == S_INIT)
                r_cnt <= '0;
            else if (sum_ld && r_cnt != 9'(N_ELEM))
                r_cnt <= r_cnt + 1'b1;
            if (w_start)
                r_err <= 1'b0;
            else if (sum_ld && (i_lt_256 == w_last))
                r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sad_ctrl.sv
// tb_sad_ctrl: directed checks of sad_ctrl (RD_LAT=0 and RD_LAT=2) against a behavioural datapath.
module tb_sad_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1, abort = 1'b0, clr_sad = 1'b0, stub = 1'b0;
    logic go[2], lt[2], inc[2], iclr[2], ld[2], sclr[2], rld[2], rclr[2], bsy[2], dn[2], er[2];
    logic [7:0] addr[2];
    logic [15:0] sum[2], sad[2];
    int n_ld[2], n_inc[2], n_st[2], n_dn[2], n_bad[2], n_gap[2], quiet[2];
    int n_pass = 0, n_tot = 0;
    int dc, b_ld, b_inc, b_st, b_dn, b_gap;

    always #5 clk = ~clk;

    sad_ctrl #(.RD_LAT(0)) dut0 (.clk(clk), .rst(rst), .go(go[0]), .abort(abort), .clr_sad(clr_sad),
        .i_lt_256(lt[0]), .i_inc(inc[0]), .i_clr(iclr[0]), .sum_ld(ld[0]), .sum_clr(sclr[0]),
        .sadreg_ld(rld[0]), .sadreg_clr(rclr[0]), .busy(bsy[0]), .done(dn[0]), .err(er[0]));
    sad_ctrl #(.RD_LAT(2)) dut2 (.clk(clk), .rst(rst), .go(go[1]), .abort(abort), .clr_sad(clr_sad),
        .i_lt_256(lt[1]), .i_inc(inc[1]), .i_clr(iclr[1]), .sum_ld(ld[1]), .sum_clr(sclr[1]),
        .sadreg_ld(rld[1]), .sadreg_clr(rclr[1]), .busy(bsy[1]), .done(dn[1]), .err(er[1]));

    // Datapath model: a = addr, b = 0; the stub forces the loop flag low at element 10.
    assign lt[0] = stub ? (addr[0] < 8'd9) : (addr[0] != 8'd255);
    assign lt[1] = (addr[1] != 8'd255);

    always @(posedge clk)
        for (int i = 0; i < 2; i++) begin
            if (iclr[i]) addr[i] <= '0; else if (inc[i]) addr[i] <= addr[i] + 8'd1;
            if (sclr[i]) sum[i] <= '0; else if (ld[i]) sum[i] <= sum[i] + 16'(addr[i]);
            if (rclr[i]) sad[i] <= '0; else if (rld[i]) sad[i] <= sum[i];
        end

    always @(negedge clk)
        for (int i = 0; i < 2; i++) begin
            logic [5:0] v;
            v = {inc[i], iclr[i], ld[i], sclr[i], rld[i], rclr[i]};
            n_ld[i]  += int'(ld[i]);
            n_inc[i] += int'(inc[i]);
            n_st[i]  += int'(rld[i]);
            n_dn[i]  += int'(dn[i]);
            if (!(v == 6'b0 || $onehot(v) || v == 6'b010100 || v == 6'b101000)) n_bad[i]++;
            if (ld[i] && quiet[i] != 2) n_gap[i]++;
            quiet[i] = (v == 6'b0) ? quiet[i] + 1 : 0;
        end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic run(input int s, output int d);
        go[s] = 1'b1;
        d = -1;
        for (int k = 1; k <= 2000; k++) begin
            tick();
            go[s] = 1'b0;
            if (dn[s] && d < 0) d = k;
            if (!bsy[s]) break;
        end
    endtask

    task automatic snap(input int s);
        b_ld = n_ld[s]; b_inc = n_inc[s]; b_st = n_st[s]; b_dn = n_dn[s]; b_gap = n_gap[s];
    endtask

    initial begin
        go[0] = 1'b0; go[1] = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_outs0", {inc[0], iclr[0], ld[0], sclr[0], rld[0], rclr[0], bsy[0], dn[0], er[0]}, 0);
        chk("reset_outs2", {inc[1], iclr[1], ld[1], sclr[1], rld[1], rclr[1], bsy[1], dn[1], er[1]}, 0);
        clr_sad = 1'b1;
        #1;
        chk("idle_sadreg_clr", rclr[0], 1);
        tick();
        clr_sad = 1'b0;
        chk("sad_cleared", sad[0], 0);

        snap(0);
        run(0, dc);
        chk("lat0_done_cycle", dc, 259);
        chk("lat0_sum_ld", n_ld[0] - b_ld, 256);
        chk("lat0_i_inc", n_inc[0] - b_inc, 255);
        chk("lat0_sadreg_ld", n_st[0] - b_st, 1);
        chk("lat0_sad", sad[0], 32640);
        chk("lat0_err", er[0], 0);

        snap(1);
        run(1, dc);
        chk("lat2_done_cycle", dc, 771);
        chk("lat2_sum_ld", n_ld[1] - b_ld, 256);
        chk("lat2_gap_viol", n_gap[1] - b_gap, 0);
        chk("lat2_sad", sad[1], 32640);

        snap(0);
        go[0] = 1'b1;
        tick();
        go[0] = 1'b0;
        repeat (99) tick();
        abort = 1'b1;
        #1;
        chk("abort_clr_strobes", {iclr[0], sclr[0]}, 2'b11);
        chk("abort_other_strobes", {inc[0], ld[0], rld[0], rclr[0]}, 0);
        tick();
        abort = 1'b0;
        chk("abort_busy", bsy[0], 0);
        repeat (5) tick();
        chk("abort_no_done", n_dn[0] - b_dn, 0);
        chk("abort_no_store", n_st[0] - b_st, 0);
        chk("abort_sad_kept", sad[0], 32640);

        stub = 1'b1;
        snap(0);
        run(0, dc);
        stub = 1'b0;
        chk("short_done_cycle", dc, 13);
        chk("short_sum_ld", n_ld[0] - b_ld, 10);
        chk("short_err", er[0], 1);
        chk("short_sad", sad[0], 45);
        run(0, dc);
        chk("err_cleared", er[0], 0);
        chk("rerun_sad", sad[0], 32640);

        go[0] = 1'b1;
        abort = 1'b1;
        tick();
        go[0] = 1'b0;
        abort = 1'b0;
        chk("go_abort_idle", bsy[0], 0);

        go[0] = 1'b1;
        tick();
        go[0] = 1'b0;
        repeat (49) tick();
        chk("pre_rst_sum_ld", ld[0], 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrun_rst_outs", {inc[0], iclr[0], ld[0], sclr[0], rld[0], rclr[0], bsy[0], dn[0], er[0]}, 0);
        run(0, dc);
        chk("post_rst_done_cycle", dc, 259);
        chk("post_rst_sad", sad[0], 32640);
        chk("strobe_combo0", n_bad[0], 0);
        chk("strobe_combo2", n_bad[1], 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
